hit_judge: RTL

Multi-lane, timing-windowed successor to the combinational note/button comparator. It tracks each lane's pending note through a hit window and edge-detects player buttons. Each lane's result is graded as perfect, good, miss or stray press. The block accumulates a saturating score and combo counter and sits between the note scroller (hit-line outputs) and the score display.

---
 rtl/hit_judge.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hit_judge.sv
// Multi-lane rhythm-game hit judge: per-lane hit windows, edge-detected buttons,
// perfect/good/miss grading with a saturating score and combo counter.
module hit_judge #(
   parameter int unsigned LANES       = 3,
   parameter int unsigned WINDOW      = 8,
   parameter int unsigned PERFECT_WIN = 2,
   parameter int unsigned PERFECT_PTS = 3,
   parameter int unsigned GOOD_PTS    = 1,
   parameter int unsigned MISS_PEN    = 1,
   parameter int unsigned SCORE_W     = 16
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               note_valid,
   input  logic [LANES-1:0]   note_lanes,
   input  logic [LANES-1:0]   player_input,
   output logic               increase_score,
   output logic               decrease_score,
   output logic [LANES-1:0]   hit_perfect,
   output logic [LANES-1:0]   hit_good,
   output logic [LANES-1:0]   miss,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] combo
);

   localparam int unsigned AGE_W   = $clog2(WINDOW);
   localparam int unsigned CNT_W   = $clog2(LANES + 1);
   localparam int unsigned DELTA_W = SCORE_W + $clog2(LANES) + 3;
   localparam int unsigned COMBO_W = SCORE_W + CNT_W;

   localparam logic [AGE_W-1:0]   AGE_LAST = AGE_W'(WINDOW - 1);
   localparam logic [AGE_W-1:0]   AGE_PERF = AGE_W'(PERFECT_WIN);
   localparam logic [SCORE_W-1:0] SAT      = '1;

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } lane_state_t;

   lane_state_t        state    [LANES];
   lane_state_t        state_nx [LANES];
   logic [AGE_W-1:0]   age      [LANES];
   logic [AGE_W-1:0]   age_nx   [LANES];
   logic [LANES-1:0]   prev_input;

   logic [LANES-1:0]   press;
   logic [LANES-1:0]   arm;
   logic [LANES-1:0]   perf_nx;
   logic [LANES-1:0]   good_nx;
   logic [LANES-1:0]   miss_nx;

   logic [CNT_W-1:0]   n_perf;
   logic [CNT_W-1:0]   n_good;
   logic [CNT_W-1:0]   n_miss;
   logic [DELTA_W-1:0] gain;
   logic [DELTA_W-1:0] loss;
   logic [DELTA_W-1:0] score_sum;
   logic [COMBO_W-1:0] combo_sum;
   logic [SCORE_W-1:0] score_nx;
   logic [SCORE_W-1:0] combo_nx;

   assign press = player_input & ~prev_input;
   assign arm   = note_valid ? note_lanes : '0;

   // State and output registers; prev_input follows the buttons even in reset
   // so a button held through reset release is not seen as a fresh press.
   always_ff @(posedge clock) begin
      prev_input <= player_input;
      if (!resetn) begin
         for (int i = 0; i < int'(LANES); i++) begin
            state[i] <= IDLE;
            age[i]   <= '0;
         end
         hit_perfect    <= '0;
         hit_good       <= '0;
         miss           <= '0;
         increase_score <= 1'b0;
         decrease_score <= 1'b0;
         score          <= '0;
         combo          <= '0;
      end else begin
         for (int i = 0; i < int'(LANES); i++) begin
            state[i] <= state_nx[i];
            age[i]   <= age_nx[i];
         end
         hit_perfect    <= perf_nx;
         hit_good       <= good_nx;
         miss           <= miss_nx;
         increase_score <= |(perf_nx | good_nx);
         decrease_score <= |miss_nx;
         score          <= score_nx;
         combo          <= combo_nx;
      end
   end

   // Per-lane next state and grading.
   always_comb begin
      perf_nx = '0;
      good_nx = '0;
      miss_nx = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         state_nx[i] = state[i];
         age_nx[i]   = age[i];
         unique case (state[i])
            IDLE: begin
               if (press[i] && arm[i]) begin
                  perf_nx[i] = 1'b1;
               end else if (press[i]) begin
                  miss_nx[i] = 1'b1;
               end else if (arm[i]) begin
                  state_nx[i] = ARMED;
                  age_nx[i]   = '0;
               end
            end
            ARMED: begin
               if (press[i] || age[i] == AGE_LAST || arm[i]) begin
                  if (press[i]) begin
                     if (age[i] <= AGE_PERF) perf_nx[i] = 1'b1;
                     else                    good_nx[i] = 1'b1;
                  end else begin
                     miss_nx[i] = 1'b1;
                  end
                  // A same-edge arm always starts a fresh window.
                  state_nx[i] = arm[i] ? ARMED : IDLE;
                  age_nx[i]   = '0;
               end else begin
                  age_nx[i] = age[i] + AGE_W'(1);
               end
            end
            default: begin
               state_nx[i] = IDLE;
               age_nx[i]   = '0;
            end
         endcase
      end
   end

   assign n_perf = CNT_W'($countones(perf_nx));
   assign n_good = CNT_W'($countones(good_nx));
   assign n_miss = CNT_W'($countones(miss_nx));

   // Score: signed-range delta, clamped into [0, SAT].
   always_comb begin
      gain      = DELTA_W'(PERFECT_PTS) * DELTA_W'(n_perf)
                + DELTA_W'(GOOD_PTS) * DELTA_W'(n_good);
      loss      = DELTA_W'(MISS_PEN) * DELTA_W'(n_miss);
      score_sum = DELTA_W'(score) + gain - loss;
      score_nx  = SCORE_W'(score_sum);
      if (score_sum[DELTA_W-1]) begin
         score_nx = '0;
      end else if (score_sum > DELTA_W'(SAT)) begin
         score_nx = SAT;
      end
   end

   // Combo: any miss in the cycle wins over hits in the same cycle.
   always_comb begin
      combo_sum = COMBO_W'(combo) + COMBO_W'(n_perf) + COMBO_W'(n_good);
      combo_nx  = SCORE_W'(combo_sum);
      if (n_miss != '0) begin
         combo_nx = '0;
      end else if (combo_sum > COMBO_W'(SAT)) begin
         combo_nx = SAT;
      end
   end

endmodule
